// File: rtl/wide_word_capture.sv
// wide_word_capture: counts 32-bit beats entering the shift converter and
// captures its parallel output into a one-word valid/ready holding register.
// Ports: clk, reset (async, active-high); beat_valid/beat_last/beat_ready
// (beat side); conv_data (converter output, newest beat in MSBs);
// word_data/word_valid/word_ready/word_last (word side); word_count
// (hand-offs, wraps); err_clear, err_partial, err_timeout (sticky flags).
// Option: define WORD_TIMEOUT_EN to abort partial words after
// TIMEOUT_CYCLES idle cycles; otherwise err_timeout is tied low.
module wide_word_capture #(
   parameter int WORD_WIDTH     = 256,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  beat_valid,
   input  logic                  beat_last,
   output logic                  beat_ready,
   input  logic [WORD_WIDTH-1:0] conv_data,
   output logic [WORD_WIDTH-1:0] word_data,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic                  word_last,
   output logic [15:0]           word_count,
   input  logic                  err_clear,
   output logic                  err_partial,
   output logic                  err_timeout
);

   localparam int N  = WORD_WIDTH / 32;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

   if (WORD_WIDTH % 32 != 0 || N < 2 || TIMEOUT_CYCLES < 1) begin : g_bad
      $error("wide_word_capture: illegal parameters");
   end

   typedef enum logic {ACCUM, CAPTURE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_cnt;
   logic                  r_last_pend;
   logic [WORD_WIDTH-1:0] r_word_data;
   logic                  r_word_valid;
   logic                  r_word_last;
   logic [15:0]           r_word_count;
   logic                  r_err_partial;
   logic                  w_beat_ready;
   logic                  w_accept;
   logic                  w_full;
   logic                  w_done;
   logic                  w_handoff;
   logic                  w_partial_ev;
   logic                  w_timeout_ev;
   logic [CW-1:0]         w_pos;

   assign w_accept  = beat_valid && w_beat_ready;
   assign w_full    = (r_cnt == LAST_BEAT);
   assign w_handoff = r_word_valid && word_ready;

   // A beat accepted in the timeout expiry cycle starts a fresh word.
   assign w_pos        = w_timeout_ev ? '0 : r_cnt;
   assign w_done       = w_accept && (w_pos == LAST_BEAT);
   assign w_partial_ev = w_accept && beat_last && (w_pos != LAST_BEAT);

`ifdef WORD_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

   logic [IW-1:0] r_idle;
   logic          r_err_timeout;

   assign w_timeout_ev = (r_idle == IDLE_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_idle <= '0;
      else if (w_accept || w_timeout_ev || r_state != ACCUM || r_cnt == '0)
         r_idle <= '0;
      else
         r_idle <= r_idle + IW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_err_timeout <= 1'b0;
      else if (w_timeout_ev)
         r_err_timeout <= 1'b1;
      else if (err_clear)
         r_err_timeout <= 1'b0;
   end

   assign err_timeout = r_err_timeout;
`else
   assign w_timeout_ev = 1'b0;
   assign err_timeout  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ACCUM;
      else
         r_state <= w_next;
   end

   // Next state: CAPTURE waits one edge for the converter to shift
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ACCUM:   if (w_done) w_next = CAPTURE;
         CAPTURE: w_next = ACCUM;
         default: w_next = ACCUM;
      endcase
   end

   // Outputs: only registered terms, so no path from word_ready
   always_comb begin
      w_beat_ready = 1'b0;
      if (r_state == ACCUM)
         w_beat_ready = !(w_full && r_word_valid);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_last_pend <= 1'b0;
      end else if (w_accept) begin
         if (w_done) begin
            r_cnt       <= '0;
            r_last_pend <= beat_last;
         end else if (beat_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= w_pos + CW'(1);
         end
      end else if (w_timeout_ev) begin
         r_cnt <= '0;
      end
   end

   // Capture cannot coincide with hand-off: completion needs an empty holder
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word_data  <= '0;
         r_word_valid <= 1'b0;
         r_word_last  <= 1'b0;
      end else if (r_state == CAPTURE) begin
         r_word_data  <= conv_data;
         r_word_valid <= 1'b1;
         r_word_last  <= r_last_pend;
      end else if (w_handoff) begin
         r_word_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_word_count <= '0;
      else if (w_handoff)
         r_word_count <= r_word_count + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_err_partial <= 1'b0;
      else if (w_partial_ev)
         r_err_partial <= 1'b1;
      else if (err_clear)
         r_err_partial <= 1'b0;
   end

   assign beat_ready  = w_beat_ready;
   assign word_data   = r_word_data;
   assign word_valid  = r_word_valid;
   assign word_last   = r_word_last;
   assign word_count  = r_word_count;
   assign err_partial = r_err_partial;

endmodule

// File: tb/tb_wide_word_capture.sv
// tb_wide_word_capture: directed and random stimulus for wide_word_capture
// against a queue-based word assembly model.
module tb_wide_word_capture;

   localparam int W = 256;
   localparam int N = W / 32;
   localparam int T = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          beat_valid;
   logic          beat_last;
   logic          beat_ready;
   logic [W-1:0]  conv_data;
   logic [W-1:0]  word_data;
   logic          word_valid;
   logic          word_ready;
   logic          word_last;
   logic [15:0]   word_count;
   logic          err_clear;
   logic          err_partial;
   logic          err_timeout;
   logic [31:0]   beat_data;

   int            n_assert = 0;
   int            n_fail   = 0;

   logic [31:0]   part[$];
   logic [W-1:0]  exp_data[$];
   logic          exp_last[$];
   logic [15:0]   m_count;
   logic          m_partial;
   logic          m_timeout;
   int            m_idle;

   always #5 clk = ~clk;

   wide_word_capture #(
      .WORD_WIDTH    (W),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .beat_valid (beat_valid),
      .beat_last  (beat_last),
      .beat_ready (beat_ready),
      .conv_data  (conv_data),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_last  (word_last),
      .word_count (word_count),
      .err_clear  (err_clear),
      .err_partial(err_partial),
      .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      part.delete();
      exp_data.delete();
      exp_last.delete();
      m_count   = '0;
      m_partial = 1'b0;
      m_timeout = 1'b0;
      m_idle    = 0;
   endtask

   // One clock: observe the handshakes, let the edge pass, update the
   // converter fixture and the model, then check the status outputs.
   task automatic tick();
      bit           acc;
      bit           hand;
      bit           bl;
      bit           clr;
      bit           ev_p;
      bit           ev_t;
      logic [31:0]  bd;
      logic [W-1:0] w;
      acc  = beat_valid && beat_ready;
      hand = word_valid && word_ready;
      bl   = beat_last;
      clr  = err_clear;
      bd   = beat_data;
      ev_p = 0;
      ev_t = 0;
      if (hand) begin
         chk("word_expected", W'(exp_data.size() != 0), W'(1));
         if (exp_data.size() != 0) begin
            chk("word_data", word_data, exp_data.pop_front());
            chk("word_last", W'(word_last), W'(exp_last.pop_front()));
         end
         m_count = m_count + 16'd1;
      end
      @(posedge clk);
      #1;
      if (acc) conv_data = {bd, conv_data[W-1:32]};
`ifdef WORD_TIMEOUT_EN
      if (part.size() != 0 && m_idle == T) begin
         part.delete();
         ev_t = 1;
      end
`endif
      if (acc) begin
         part.push_back(bd);
         if (part.size() == N) begin
            w = '0;
            for (int i = 0; i < N; i++) w[32*i +: 32] = part[i];
            exp_data.push_back(w);
            exp_last.push_back(bl);
            part.delete();
         end else if (bl) begin
            part.delete();
            ev_p = 1;
         end
         m_idle = 0;
      end else if (part.size() != 0) begin
         m_idle++;
      end else begin
         m_idle = 0;
      end
      m_partial = ev_p ? 1'b1 : (clr ? 1'b0 : m_partial);
      m_timeout = ev_t ? 1'b1 : (clr ? 1'b0 : m_timeout);
      chk("err_partial", W'(err_partial), W'(m_partial));
      chk("err_timeout", W'(err_timeout), W'(m_timeout));
      chk("word_count", W'(word_count), W'(m_count));
   endtask

   task automatic send_beat(input logic [31:0] d, input bit last);
      bit done;
      done       = 0;
      beat_valid = 1'b1;
      beat_data  = d;
      beat_last  = last;
      for (int k = 0; k < 64 && !done; k++) begin
         done = beat_ready;
         tick();
      end
      chk("beat_accepted", W'(done), W'(1));
      beat_valid = 1'b0;
      beat_last  = 1'b0;
   endtask

   task automatic drain();
      beat_valid = 1'b0;
      word_ready = 1'b1;
      repeat (5) tick();
      chk("queue_drained", W'(exp_data.size()), W'(0));
   endtask

   initial begin
      logic [W-1:0] e;
      int           idx;
      bit           a;

      reset      = 1'b1;
      beat_valid = 1'b0;
      beat_last  = 1'b0;
      beat_data  = '0;
      word_ready = 1'b0;
      err_clear  = 1'b0;
      conv_data  = '0;
      model_reset();

      // Reset state
      @(negedge clk);
      chk("rst_word_valid", W'(word_valid), W'(0));
      chk("rst_word_data", word_data, W'(0));
      chk("rst_word_last", W'(word_last), W'(0));
      chk("rst_word_count", W'(word_count), W'(0));
      chk("rst_err_partial", W'(err_partial), W'(0));
      chk("rst_err_timeout", W'(err_timeout), W'(0));
      chk("rst_beat_ready", W'(beat_ready), W'(1));
      reset = 1'b0;

      // Basic word: beats 1..8, valid two edges after the last beat
      word_ready = 1'b1;
      for (int i = 0; i < N; i++) send_beat(32'(i + 1), 1'b0);
      chk("lat_edge1_valid", W'(word_valid), W'(0));
      tick();
      e = '0;
      for (int i = 0; i < N; i++) e[32*i +: 32] = 32'(i + 1);
      chk("lat_edge2_valid", W'(word_valid), W'(1));
      chk("first_word_data", word_data, e);
      tick();
      chk("first_count", W'(word_count), W'(1));

      // Back-pressure: 16 beats offered while consumer stalls
      word_ready = 1'b0;
      idx        = 0;
      beat_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         beat_data = 32'h100 + 32'(idx);
         a         = beat_ready;
         tick();
         if (a) idx++;
      end
      chk("stall_beats_taken", W'(idx), W'(N + N - 1));
      chk("stall_beat_ready", W'(beat_ready), W'(0));
      chk("stall_word_valid", W'(word_valid), W'(1));
      word_ready = 1'b1;
      for (int k = 0; k < 20 && idx < 2 * N; k++) begin
         beat_data = 32'h100 + 32'(idx);
         a         = beat_ready;
         tick();
         if (a) idx++;
      end
      chk("stall_all_beats", W'(idx), W'(2 * N));
      drain();
      chk("stall_count", W'(word_count), W'(3));

      // beat_last on the final beat sets word_last
      for (int i = 0; i < N; i++) send_beat($urandom, i == N - 1);
      tick();
      chk("last_word_valid", W'(word_valid), W'(1));
      chk("last_word_last", W'(word_last), W'(1));
      drain();

      // Truncated stream: beat_last on beat 5
      for (int i = 0; i < 5; i++) send_beat($urandom, i == 4);
      chk("partial_flag", W'(err_partial), W'(1));
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("partial_no_word", W'(word_valid), W'(0));
      end
      for (int i = 0; i < N; i++) send_beat($urandom, 1'b0);
      drain();
      chk("after_partial_count", W'(word_count), W'(5));
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("partial_cleared", W'(err_partial), W'(0));

      // Reset during CAPTURE discards the pending word
      for (int i = 0; i < N; i++) send_beat($urandom, 1'b0);
      reset = 1'b1;
      #1;
      chk("capt_rst_valid", W'(word_valid), W'(0));
      chk("capt_rst_count", W'(word_count), W'(0));
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("capt_rst_still_idle", W'(word_valid), W'(0));
      for (int i = 0; i < N; i++) send_beat($urandom, 1'b0);
      tick();
      chk("capt_rst_new_valid", W'(word_valid), W'(1));
      drain();
      chk("capt_rst_new_count", W'(word_count), W'(1));

`ifdef WORD_TIMEOUT_EN
      // Mid-word idle timeout
      for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0);
      repeat (T + 1) tick();
      chk("timeout_flag", W'(err_timeout), W'(1));
      for (int i = 0; i < N; i++) send_beat($urandom, 1'b0);
      drain();
      chk("timeout_clean_word", W'(word_count), W'(2));
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("timeout_cleared", W'(err_timeout), W'(0));
`endif

      // Hand-off counter wraps from 0xFFFF
      force dut.r_word_count = 16'hFFFF;
      #1;
      release dut.r_word_count;
      m_count = 16'hFFFF;
      chk("wrap_preload", W'(word_count), W'(16'hFFFF));
      for (int i = 0; i < N; i++) send_beat($urandom, 1'b0);
      drain();
      chk("wrap_count", W'(word_count), W'(0));

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         beat_valid = ($urandom_range(0, 99) < 70);
         beat_data  = $urandom;
         beat_last  = ($urandom_range(0, 99) < 4);
         word_ready = ($urandom_range(0, 99) < 60);
         err_clear  = ($urandom_range(0, 99) < 3);
         tick();
      end
      err_clear = 1'b0;
      beat_last = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
